led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED driver; the next generation of the board-level blinker.
- Each channel runs its own mode (OFF, ON, BLINK, BREATHE) and its own rate, set at runtime through a single-cycle write port.
- Per-channel output polarity suits mixed active-high and active-low LEDs on one board.
- Sits at top level between the board clock and the LED pins; a sequencer or UART register file drives the write port.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- TICK_HZ, 1000, timebase tick rate. DIV = CLK_HZ/TICK_HZ; DIV must be >= 2, else elaboration error.
- NUM_LEDS, 7, number of channels (1..16).
- PWM_BITS, 8, brightness resolution for BREATHE.
- ACTIVE_LOW_MASK, 7'b0000011, bit i = 1 means LED[i] is active-low.
- BOOT_BLINK_MASK, 7'b0000001, channels that leave reset in BLINK mode.
- BOOT_RATE, 8'd249, rate loaded at reset into BOOT_BLINK_MASK channels.

Ports:
- CLK, input, 1, system clock.
- RST_N, input, 1, asynchronous active-low reset.
- WR_EN, input, 1, write strobe, sampled on rising edge.
- WR_CH, input, max(1,$clog2(NUM_LEDS)), target channel.
- WR_MODE, input, 2, 0=OFF, 1=ON, 2=BLINK, 3=BREATHE.
- WR_RATE, input, 8, rate value.
- SYNC, input, 1, realign all channels and the timebase.
- TICK, output, 1, one-cycle timebase pulse (for debug and chaining).
- LED, output, NUM_LEDS, registered pin drive.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Prescaler = 0, TICK = 0, PWM counter = 0.
  - Channel state: phase = 0, blink_q = 0, brightness = 0, direction = up.
  - Mode/rate: BLINK with BOOT_RATE for BOOT_BLINK_MASK channels; OFF with rate 0 for all others.
  - LED[i] = ACTIVE_LOW_MASK[i], i.e. every LED at its inactive level.
- Prescaler: counts 0..DIV-1 and wraps. TICK = 1 for exactly the cycle in which the count equals DIV-1.
- PWM counter: PWM_BITS wide, free-running, increments every clock, wraps to 0.
- Logical on-state per channel:
  - OFF: 0.
  - ON: 1.
  - BLINK: blink_q.
  - BREATHE: (brightness > pwm_cnt).
- BLINK stepping: on each TICK, if phase == rate then phase <= 0 and blink_q toggles; else phase++. Half-period = (rate+1) ticks; rate 0 toggles every tick.
- BREATHE stepping:
  - Same phase rule, but each wrap steps brightness by ±1.
  - At 2^PWM_BITS-1 while direction is up: direction flips to down, and brightness holds for that step.
  - At 0 while direction is down: direction flips to up, and brightness holds for that step.
  - Brightness never wraps.
- OFF and ON: phase, blink_q and brightness stay frozen.
- Output: LED[i] <= on_i XOR ACTIVE_LOW_MASK[i], registered. One clock of latency from internal state to pin.
- Write:
  - When WR_EN = 1 and WR_CH < NUM_LEDS, the mode and rate load on that edge.
  - The same edge clears phase, blink_q and brightness, and sets direction = up. This applies even when the new mode equals the old one (restart).
  - The new mode is visible on LED one further cycle later.
  - WR_CH >= NUM_LEDS: write ignored, no state change.
- SYNC = 1 on an edge: prescaler, PWM counter and every channel's phase, blink_q, brightness and direction are cleared. Mode and rate are retained.
- Simultaneous events:
  - SYNC and WR_EN together: the write's mode/rate load, and all channels clear.
  - TICK coinciding with WR_EN on the target channel: the write wins and the channel does not step on that tick.
  - TICK coinciding with SYNC: SYNC wins and no channel steps.
- Reset mid-operation: immediate return to reset state regardless of mode, tick phase or pending write. No glitch beyond the reset transition itself.

Test Plan:
- CLK_HZ=1000, TICK_HZ=100 (DIV=10), release reset -> TICK high on cycles 9, 19, 29…; LED[0] toggles every 250 ticks (BOOT_RATE=249); LED[1]=1 (active-low, off); LED[6:2]=0.
- Write ch2 BLINK rate 0 -> LED[2] toggles on every tick, first toggle exactly 1 clock after the first TICK following the write; half-period = 10 clocks.
- Write ch3 ON, then ch3 OFF, then WR_CH=9 ON -> LED[3] goes 1 two clocks after the first write, 0 after the second; the third write changes no output or state.
- PWM_BITS=3, write ch4 BREATHE rate 0 -> brightness sequence 0,1,…,7,7,6,…,0,0,1 per tick; LED[4] high duty = brightness/8 over each 8-clock PWM window.
- Ch2 and ch5 in BLINK with the same rate but offset phase, pulse SYNC -> both restart from 0 and toggle on identical cycles thereafter; TICK's next pulse lands exactly DIV cycles after SYNC.
- Assert RST_N low mid-BREATHE and mid-prescaler count -> all LEDs go to the inactive level asynchronously, before the next edge; after release, the boot pattern repeats identically to the first test.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared tick prescaler and PWM counter drive
// per-channel OFF/ON/BLINK/BREATHE engines with runtime mode/rate writes and output polarity.
module led_pattern_gen #(
    parameter int unsigned         CLK_HZ          = 12000000,
    parameter int unsigned         TICK_HZ         = 1000,
    parameter int unsigned         NUM_LEDS        = 7,
    parameter int unsigned         PWM_BITS        = 8,
    parameter logic [NUM_LEDS-1:0] ACTIVE_LOW_MASK = 7'b0000011,
    parameter logic [NUM_LEDS-1:0] BOOT_BLINK_MASK = 7'b0000001,
    parameter logic [7:0]          BOOT_RATE       = 8'd249,
    localparam int unsigned        CH_W            = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                WR_EN,
    input  logic [CH_W-1:0]     WR_CH,
    input  logic [1:0]          WR_MODE,
    input  logic [7:0]          WR_RATE,
    input  logic                SYNC,
    output logic                TICK,
    output logic [NUM_LEDS-1:0] LED
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

    if (DIV < 2) begin : g_bad_div
        $error("led_pattern_gen: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_bad_num
        $error("led_pattern_gen: NUM_LEDS must be in 1..16");
    end

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeOn      = 2'd1,
        ModeBlink   = 2'd2,
        ModeBreathe = 2'd3
    } mode_e;

    function automatic logic [NUM_LEDS-1:0][1:0] boot_mode();
        boot_mode = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            boot_mode[i] = BOOT_BLINK_MASK[i] ? ModeBlink : ModeOff;
        end
    endfunction

    function automatic logic [NUM_LEDS-1:0][7:0] boot_rate();
        boot_rate = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            boot_rate[i] = BOOT_BLINK_MASK[i] ? BOOT_RATE : 8'd0;
        end
    endfunction

    localparam logic [NUM_LEDS-1:0][1:0] BOOT_MODE = boot_mode();
    localparam logic [NUM_LEDS-1:0][7:0] BOOT_RATES = boot_rate();

    logic [CNT_W-1:0]                   presc_q, presc_d;
    logic [PWM_BITS-1:0]                pwm_q, pwm_d;
    logic [NUM_LEDS-1:0][1:0]           mode_q, mode_d;
    logic [NUM_LEDS-1:0][7:0]           rate_q, rate_d;
    logic [NUM_LEDS-1:0][7:0]           phase_q, phase_d;
    logic [NUM_LEDS-1:0]                blink_q, blink_d;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  bright_q, bright_d;
    logic [NUM_LEDS-1:0]                down_q, down_d;
    logic [NUM_LEDS-1:0]                led_q, led_d;
    logic                               tick;
    logic                               wr_ok;

    assign tick  = (presc_q == CNT_MAX);
    assign TICK  = tick;
    assign LED   = led_q;
    assign wr_ok = WR_EN && (32'(WR_CH) < NUM_LEDS);

    always_comb begin
        presc_d = (SYNC || tick) ? '0 : presc_q + 1'b1;
        pwm_d   = SYNC ? '0 : pwm_q + 1'b1;
    end

    always_comb begin
        mode_d   = mode_q;
        rate_d   = rate_q;
        phase_d  = phase_q;
        blink_d  = blink_q;
        bright_d = bright_q;
        down_d   = down_q;
        led_d    = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            // Pin drive reflects the state held this cycle.
            case (mode_q[i])
                ModeOff:     led_d[i] = 1'b0;
                ModeOn:      led_d[i] = 1'b1;
                ModeBlink:   led_d[i] = blink_q[i];
                ModeBreathe: led_d[i] = (bright_q[i] > pwm_q);
                default:     led_d[i] = 1'b0;
            endcase
            led_d[i] = led_d[i] ^ ACTIVE_LOW_MASK[i];

            if (SYNC) begin
                phase_d[i]  = '0;
                blink_d[i]  = 1'b0;
                bright_d[i] = '0;
                down_d[i]   = 1'b0;
            end else if (tick && (mode_q[i] == ModeBlink || mode_q[i] == ModeBreathe)) begin
                if (phase_q[i] == rate_q[i]) begin
                    phase_d[i] = '0;
                    if (mode_q[i] == ModeBlink) begin
                        blink_d[i] = ~blink_q[i];
                    end else if (!down_q[i]) begin
                        // Turnaround steps hold the level so each extreme lasts two steps.
                        if (bright_q[i] == BRIGHT_MAX) begin
                            down_d[i] = 1'b1;
                        end else begin
                            bright_d[i] = bright_q[i] + 1'b1;
                        end
                    end else begin
                        if (bright_q[i] == '0) begin
                            down_d[i] = 1'b0;
                        end else begin
                            bright_d[i] = bright_q[i] - 1'b1;
                        end
                    end
                end else begin
                    phase_d[i] = phase_q[i] + 8'd1;
                end
            end

            // A write restarts its channel and overrides any step on the same edge.
            if (wr_ok && (32'(WR_CH) == i)) begin
                mode_d[i]   = WR_MODE;
                rate_d[i]   = WR_RATE;
                phase_d[i]  = '0;
                blink_d[i]  = 1'b0;
                bright_d[i] = '0;
                down_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q  <= '0;
            pwm_q    <= '0;
            mode_q   <= BOOT_MODE;
            rate_q   <= BOOT_RATES;
            phase_q  <= '0;
            blink_q  <= '0;
            bright_q <= '0;
            down_q   <= '0;
            led_q    <= ACTIVE_LOW_MASK;
        end else begin
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            mode_q   <= mode_d;
            rate_q   <= rate_d;
            phase_q  <= phase_d;
            blink_q  <= blink_d;
            bright_q <= bright_d;
            down_q   <= down_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a wrap-count reference model.
module tb_led_pattern_gen;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned TICK_HZ   = 100;
    localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
    localparam int unsigned NUM_LEDS  = 7;
    localparam int unsigned PWM_BITS  = 3;
    localparam int unsigned PWM_N     = 1 << PWM_BITS;
    localparam int unsigned CH_W      = 3;
    localparam logic [6:0]  ALM       = 7'b0000011;
    localparam logic [6:0]  BBM       = 7'b0000001;
    localparam logic [7:0]  BOOT_RATE = 8'd249;

    logic            CLK     = 1'b0;
    logic            RST_N   = 1'b0;
    logic            WR_EN   = 1'b0;
    logic [CH_W-1:0] WR_CH   = '0;
    logic [1:0]      WR_MODE = '0;
    logic [7:0]      WR_RATE = '0;
    logic            SYNC    = 1'b0;
    logic            TICK;
    logic [6:0]      LED;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: ticks since last wrap and number of wraps since restart.
    int         m_presc, m_pwm;
    int         m_mode  [NUM_LEDS];
    int         m_rate  [NUM_LEDS];
    int         m_phase [NUM_LEDS];
    int         m_wraps [NUM_LEDS];
    logic [6:0] m_led;

    led_pattern_gen #(
        .CLK_HZ          (CLK_HZ),
        .TICK_HZ         (TICK_HZ),
        .NUM_LEDS        (NUM_LEDS),
        .PWM_BITS        (PWM_BITS),
        .ACTIVE_LOW_MASK (ALM),
        .BOOT_BLINK_MASK (BBM),
        .BOOT_RATE       (BOOT_RATE)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .WR_EN   (WR_EN),
        .WR_CH   (WR_CH),
        .WR_MODE (WR_MODE),
        .WR_RATE (WR_RATE),
        .SYNC    (SYNC),
        .TICK    (TICK),
        .LED     (LED)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_presc = 0;
        m_pwm   = 0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            m_mode[i]  = BBM[i] ? 2 : 0;
            m_rate[i]  = BBM[i] ? int'(BOOT_RATE) : 0;
            m_phase[i] = 0;
            m_wraps[i] = 0;
        end
        m_led = ALM;
    endfunction

    // Triangle 0..max,max..0 with period 2*PWM_N wraps.
    function automatic int tri_level(input int w);
        int p = w % (2 * PWM_N);
        return (p < PWM_N) ? p : (2 * PWM_N - 1 - p);
    endfunction

    function automatic bit model_on(input int i);
        case (m_mode[i])
            1:       return 1'b1;
            2:       return (m_wraps[i] % 2) == 1;
            3:       return tri_level(m_wraps[i]) > m_pwm;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_step(input bit we, input int ch, input int md, input int rt,
                                       input bit sy);
        bit tick = (m_presc == DIV - 1);
        for (int i = 0; i < NUM_LEDS; i++) m_led[i] = model_on(i) ^ ALM[i];
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (sy) begin
                m_phase[i] = 0;
                m_wraps[i] = 0;
            end else if (tick && m_mode[i] >= 2) begin
                if (m_phase[i] == m_rate[i]) begin
                    m_phase[i] = 0;
                    m_wraps[i]++;
                end else begin
                    m_phase[i]++;
                end
            end
        end
        if (we && ch < NUM_LEDS) begin
            m_mode[ch]  = md;
            m_rate[ch]  = rt;
            m_phase[ch] = 0;
            m_wraps[ch] = 0;
        end
        m_presc = sy ? 0 : (m_presc + 1) % DIV;
        m_pwm   = sy ? 0 : (m_pwm + 1) % PWM_N;
    endfunction

    task automatic drive(input bit we, input int ch, input int md, input int rt, input bit sy);
        WR_EN   = we;
        WR_CH   = CH_W'(ch);
        WR_MODE = 2'(md);
        WR_RATE = 8'(rt);
        SYNC    = sy;
        model_step(we, ch, md, rt, sy);
        @(negedge CLK);
        check_eq("tick", 32'(TICK), 32'(m_presc == DIV - 1));
        check_eq("led", 32'(LED), 32'(m_led));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_eq("rst_led", 32'(LED), 32'(ALM));
        check_eq("rst_tick", 32'(TICK), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Boot pattern: ch0 toggles every 250 ticks.
        idle(2600);

        // ch2 BLINK rate 0.
        drive(1'b1, 2, 2, 0, 1'b0);
        idle(50);

        // ch3 ON, OFF, then an out-of-range write.
        drive(1'b1, 3, 1, 0, 1'b0);
        idle(5);
        drive(1'b1, 3, 0, 0, 1'b0);
        idle(5);
        drive(1'b1, 7, 1, 5, 1'b0);
        idle(5);

        // ch4 BREATHE rate 0: full triangle and beyond.
        drive(1'b1, 4, 3, 0, 1'b0);
        idle(400);

        // ch5 and ch2 BLINK, same rate, offset start, then SYNC realigns.
        drive(1'b1, 5, 2, 2, 1'b0);
        idle(17);
        drive(1'b1, 2, 2, 2, 1'b0);
        idle(60);
        drive(1'b0, 0, 0, 0, 1'b1);
        idle(120);

        // Write and SYNC together, and a write landing on a tick.
        drive(1'b1, 6, 2, 1, 1'b1);
        idle(8);
        drive(1'b1, 6, 2, 0, 1'b0);
        idle(40);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 19) == 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 199) == 0);
        end

        // Asynchronous reset mid-BREATHE and mid-prescaler count.
        drive(1'b1, 4, 3, 0, 1'b0);
        drive(1'b1, 2, 1, 0, 1'b0);
        idle(123);
        #3;
        WR_EN   = 1'b1;
        WR_CH   = 3'd3;
        WR_MODE = 2'd1;
        RST_N   = 1'b0;
        #1;
        check_eq("async_led", 32'(LED), 32'(ALM));
        check_eq("async_tick", 32'(TICK), 32'd0);
        model_reset();
        @(negedge CLK);
        check_eq("hold_led", 32'(LED), 32'(ALM));
        RST_N = 1'b1;
        idle(2600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
